// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store SRAM controller: funct3 codes, FSM states
// and the store-lane / request-legality helpers.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    typedef struct packed {
        logic [7:0]  wmask;
        logic [31:0] wdata;
    } store_lane_t;

    // Stores replicate the right-aligned data across the word; the mask picks the lanes.
    function automatic store_lane_t store_lanes(input logic [2:0]  func3,
                                                input logic [1:0]  off,
                                                input logic [31:0] data);
        store_lane_t s;
        s.wmask = '0;
        s.wdata = '0;
        case (func3)
            F3_B: begin
                s.wmask = {4'b0000, 4'b0001 << off};
                s.wdata = {4{data[7:0]}};
            end
            F3_H: begin
                s.wmask = {4'b0000, 4'b0011 << off};
                s.wdata = {2{data[15:0]}};
            end
            F3_W: begin
                s.wmask = 8'b0000_1111;
                s.wdata = data;
            end
            default: ;
        endcase
        return s;
    endfunction

    function automatic logic is_illegal(input logic [2:0] func3, input logic wen);
        case (func3)
            F3_B, F3_H, F3_W: return 1'b0;
            F3_BU, F3_HU:     return wen;
            default:          return 1'b1;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] func3, input logic [1:0] off);
        case (func3)
            F3_H, F3_HU: return off[0];
            F3_W:        return off != 2'b00;
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Load-data lane extraction: selects the byte/half addressed by off and
// sign- or zero-extends it according to funct3.
module lsu_load_ext
    import lsu_pkg::*;
(
    input  logic [31:0] data,
    input  logic [1:0]  off,
    input  logic [2:0]  func3,
    output logic [31:0] rdata
);

    logic [31:0] shifted;

    assign shifted = data >> {off, 3'b000};

    always_comb begin
        // NOTE: default assignment first so no path through the case infers a latch.
        rdata = '0;
        case (func3)
            F3_B:    rdata = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    rdata = {{16{shifted[15]}}, shifted[15:0]};
            F3_W:    rdata = data;
            F3_BU:   rdata = {24'b0, shifted[7:0]};
            F3_HU:   rdata = {16'b0, shifted[15:0]};
            default: rdata = '0;
        endcase
    end

endmodule

// File: rtl/lsu_sram_ctrl.sv
// LSU back end: one RV32 load/store per transaction onto a single-port SRAM,
// with a registered, error-flagged response.
module lsu_sram_ctrl
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [2:0]  req_func3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        sram_ren,
    output logic        sram_wen,
    output logic [7:0]  sram_wmask,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_data,
    input  logic        sram_valid
);

    state_t           state, next_state;
    logic [2:0]       lat_func3;
    logic [1:0]       lat_off;
    logic             lat_wen;
    logic [CNT_W-1:0] cnt;
    logic             req_bad;
    logic             timeout_hit;
    logic [31:0]      ext_rdata;
    store_lane_t      lanes;

    assign req_bad     = is_illegal(req_func3, req_wen) || is_misaligned(req_func3, req_addr[1:0]);
    assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));
    assign lanes       = store_lanes(req_func3, req_addr[1:0], req_wdata);

    lsu_load_ext u_load_ext (
        .data  (sram_data),
        .off   (lat_off),
        .func3 (lat_func3),
        .rdata (ext_rdata)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (req_valid) next_state = req_bad ? RESP : WAIT;
            WAIT:    if (sram_valid || timeout_hit) next_state = RESP;
            RESP:    if (resp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Handshake flags decode the registered state only, so they never see the inputs.
    always_comb begin
        req_ready  = (state == IDLE);
        resp_valid = (state == RESP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_func3  <= '0;
            lat_off    <= '0;
            lat_wen    <= 1'b0;
            cnt        <= '0;
            sram_ren   <= 1'b0;
            sram_wen   <= 1'b0;
            sram_wmask <= '0;
            sram_addr  <= '0;
            sram_wdata <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    lat_func3 <= req_func3;
                    lat_off   <= req_addr[1:0];
                    lat_wen   <= req_wen;
                    cnt       <= '0;
                    if (req_bad) begin
                        resp_rdata <= '0;
                        resp_err   <= 1'b1;
                    end else begin
                        sram_ren   <= ~req_wen;
                        sram_wen   <= req_wen;
                        sram_addr  <= {req_addr[31:2], 2'b00};
                        sram_wmask <= req_wen ? lanes.wmask : 8'h00;
                        sram_wdata <= req_wen ? lanes.wdata : 32'h0;
                    end
                end
                WAIT: begin
                    cnt <= cnt + 1'b1;
                    // A completion on the final WAIT cycle still counts as success.
                    if (sram_valid) begin
                        sram_ren   <= 1'b0;
                        sram_wen   <= 1'b0;
                        resp_rdata <= lat_wen ? 32'h0 : ext_rdata;
                        resp_err   <= 1'b0;
                    end else if (timeout_hit) begin
                        sram_ren   <= 1'b0;
                        sram_wen   <= 1'b0;
                        resp_rdata <= '0;
                        resp_err   <= 1'b1;
                    end
                end
                RESP: if (resp_ready) begin
                    resp_rdata <= '0;
                    resp_err   <= 1'b0;
                    cnt        <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule
